pulse_meas: RTL and testbench
=============================

# pulse_meas

Serial-level pulse measurer: the receiving end of the single-bit `d` stimulus stream that our sequential labs drive on negedge and capture on posedge. It synchronizes the incoming level, counts the length of each low run and the following high run in clock cycles, and publishes one {low length, high length} record per completed pulse over a valid/ready output. It sits between any single-bit source (button, flip-flop output, serial line) and downstream logic that needs pulse widths.

## Interface
Parameters:
- `CNT_W`, 8: width of each run-length counter and output field; counts saturate at 2^CNT_W−1.
- `SYNC_STAGES`, 2: flops in the input synchronizer; 0 = bypass (`d` used directly); legal 0..4.

Ports:
- `clk`  in  1  single clock; everything samples on posedge.
- `rst`  in  1  synchronous, active-high reset.
- `d`  in  1  serial input level.
- `m_ready`  in  1  downstream accepts record this cycle.
- `m_valid`  out  1  record held on `m_low_len`/`m_high_len`.
- `m_low_len`  out  CNT_W  cycles `d_s` was low before the pulse.
- `m_high_len`  out  CNT_W  cycles `d_s` was high (pulse width).
- `m_sat`  out  1  either field saturated in this record.
- `dropped`  out  1  one-cycle strobe: completed record discarded because output was full.

## Operation
- `d_s` = `d` after SYNC_STAGES flops; synchronizer flops reset to 0.
- FSM states (registered, reset → ARM):
  - ARM: discard any partial pulse present at reset. `d_s`=0 → LOW, `low_cnt`=1. `d_s`=1 → stay.
  - LOW: `d_s`=0 → `low_cnt` saturating +1. `d_s`=1 → HIGH, `high_cnt`=1.
  - HIGH: `d_s`=1 → `high_cnt` saturating +1. `d_s`=0 → publish {low_cnt, high_cnt}, → LOW, `low_cnt`=1.
- Saturation: counter holds at 2^CNT_W−1, never wraps; `m_sat`=1 in the published record if either field is at max.
- Output register (single slot):
  - publish and (`m_valid`=0 or `m_ready`=1) → load record, `m_valid`=1.
  - publish and `m_valid`=1 and `m_ready`=0 → held record kept unchanged, new record lost, `dropped`=1 for that cycle.
  - no publish and `m_ready`=1 → `m_valid`=0.
  - fields remain stable while `m_valid`=1 and `m_ready`=0.
- Reset (any time, including mid-pulse): state ARM, counters 0, sync flops 0, `m_valid`=0, `m_low_len`=0, `m_high_len`=0, `m_sat`=0, `dropped`=0. A held unaccepted record is lost.

## Timing
- `d` sampled at posedge; `d_s` lags `d` by SYNC_STAGES cycles.
- Publish occurs at the posedge where HIGH sees `d_s`=0; `m_valid` is high starting the cycle after that edge. A `d` falling edge therefore reaches `m_valid` SYNC_STAGES+1 cycles after it is first sampled low.
- Handshake transfer = posedge with `m_valid`=1 and `m_ready`=1. `m_ready` may be tied 1.
- Minimum pulse: one cycle high and one cycle low → record `{1,1}`; back-to-back records possible every 2 cycles.
- First record after reset: `low_len` counts from the first `d_s`=0 cycle after reset release (includes synchronizer fill cycles).

## Structure
- `pulse_meas_pkg`: `typedef enum logic [1:0] {ARM, LOW, HIGH} pm_state_t`; `localparam` helper for saturation max is derived from CNT_W in the module, not the package.
- One sub-module: `sync_chain` (parameter STAGES, ports clk, rst, d, q; STAGES=0 is a wire). All FSM, counters and output register live in `pulse_meas`.

## Test plan
- SYNC_STAGES=0, CNT_W=8: rst 1 cycle; `d`=0 for 5 cycles, 1 for 3, then 0 (changes on negedge) → one record `low=5, high=3, sat=0`, `m_valid` rises the cycle after first low sample.
- `d`=1 during and 4 cycles after reset, then 0 for 2, 1 for 2, 0 → partial pulse ignored; only record `low=2, high=2`.
- CNT_W=4: `d` low 20 cycles, high 1, low → `low=15, high=1, sat=1`.
- `m_ready`=0, two complete pulses (`{3,2}` then `{4,1}`) → `m_valid` holds `{3,2}`, `dropped` pulses once at second publish; raise `m_ready` → `m_valid` drops next cycle.
- `m_ready`=1 with alternating 1-cycle high/low → records `{1,1}` every 2 cycles, no `dropped`; SYNC_STAGES=2 repeat → same records, each delayed 2 cycles.
- Assert `rst` mid-HIGH with record held → all outputs 0 next cycle, state ARM, no record from the interrupted pulse.

Source files
------------

// File: rtl/pulse_meas_pkg.sv
// pulse_meas_pkg: shared FSM state type for the pulse measurer
package pulse_meas_pkg;
  typedef enum logic [1:0] {ARM, LOW, HIGH} pm_state_t;
endpackage

// File: rtl/sync_chain.sv
// sync_chain: STAGES-deep reset-to-0 synchronizer (clk, rst, d -> q); STAGES=0 is a plain wire
module sync_chain #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  if (STAGES == 0) begin : g_wire
    assign q = d;
  end else begin : g_ff
    logic [STAGES-1:0] r;
    always_ff @(posedge clk)
      if (rst) r <= '0;
      else r <= STAGES'({r, d});
    assign q = r[STAGES-1];
  end
endmodule

// File: rtl/pulse_meas.sv
// pulse_meas: measures low/high run lengths of d and publishes {low,high} records over valid/ready (clk, rst, d, m_ready -> m_valid, m_low_len, m_high_len, m_sat, dropped)
module pulse_meas
  import pulse_meas_pkg::*;
#(
  parameter int CNT_W       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             d,
  input  logic             m_ready,
  output logic             m_valid,
  output logic [CNT_W-1:0] m_low_len,
  output logic [CNT_W-1:0] m_high_len,
  output logic             m_sat,
  output logic             dropped
);
  localparam logic [CNT_W-1:0] MAX = '1;
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);
  pm_state_t state;
  logic ds, publish;
  logic [CNT_W-1:0] low_cnt, high_cnt, low_inc, high_inc;
  sync_chain #(.STAGES(SYNC_STAGES)) u_sync (.clk(clk), .rst(rst), .d(d), .q(ds));
  always_comb begin
    publish  = state == HIGH && !ds;
    low_inc  = low_cnt == MAX ? low_cnt : low_cnt + ONE;
    high_inc = high_cnt == MAX ? high_cnt : high_cnt + ONE;
  end
  always_ff @(posedge clk)
    if (rst) begin
      state      <= ARM;
      low_cnt    <= '0;
      high_cnt   <= '0;
      m_valid    <= 1'b0;
      m_low_len  <= '0;
      m_high_len <= '0;
      m_sat      <= 1'b0;
      dropped    <= 1'b0;
    end else begin
      dropped <= publish && m_valid && !m_ready;
      case (state)
        ARM:
          if (!ds) begin
            state   <= LOW;
            low_cnt <= ONE;
          end
        LOW:
          if (ds) begin
            state    <= HIGH;
            high_cnt <= ONE;
          end else low_cnt <= low_inc;
        HIGH:
          if (ds) high_cnt <= high_inc;
          else begin
            state   <= LOW;
            low_cnt <= ONE;
          end
        default: state <= ARM;
      endcase
      if (publish && (!m_valid || m_ready)) begin
        m_valid    <= 1'b1;
        m_low_len  <= low_cnt;
        m_high_len <= high_cnt;
        m_sat      <= low_cnt == MAX || high_cnt == MAX;
      end else if (!publish && m_ready) m_valid <= 1'b0;
    end
endmodule

// File: tb/tb_pulse_meas.sv
// tb_pulse_meas: directed + random check of two pulse_meas configurations against a run-length history model
module tb_pulse_meas;
  logic clk = 1'b0, rst = 1'b1, d = 1'b0, m_ready = 1'b1;
  logic v0, s0, dr0, v1, s1, dr1;
  logic [7:0] l0, h0;
  logic [3:0] l1, h1;
  int checks = 0, passed = 0;
  bit dq[$];
  int sst[2] = '{0, 2};
  int wid[2] = '{8, 4};
  int mx[2]  = '{255, 15};
  int mv[2], ml[2], mh[2], ms[2], md[2];

  always #5 clk = ~clk;

  pulse_meas #(.CNT_W(8), .SYNC_STAGES(0)) dut0 (
    .clk(clk), .rst(rst), .d(d), .m_ready(m_ready), .m_valid(v0),
    .m_low_len(l0), .m_high_len(h0), .m_sat(s0), .dropped(dr0));
  pulse_meas #(.CNT_W(4), .SYNC_STAGES(2)) dut1 (
    .clk(clk), .rst(rst), .d(d), .m_ready(m_ready), .m_valid(v1),
    .m_low_len(l1), .m_high_len(h1), .m_sat(s1), .dropped(dr1));

  function automatic bit dsv(int s, int k);
    return (k >= s) ? dq[k-s] : 1'b0;
  endfunction

  task automatic model_edge();
    int k, j, lo, hi;
    bit pub;
    if (rst) begin
      dq.delete();
      for (int i = 0; i < 2; i++) begin
        mv[i] = 0; ml[i] = 0; mh[i] = 0; ms[i] = 0; md[i] = 0;
      end
      return;
    end
    dq.push_back(d);
    k = dq.size() - 1;
    for (int i = 0; i < 2; i++) begin
      pub = 0; lo = 0; hi = 0;
      if (k >= 1 && !dsv(sst[i], k) && dsv(sst[i], k-1)) begin
        j = k - 1;
        while (j >= 0 && dsv(sst[i], j)) begin hi++; j--; end
        while (j >= 0 && !dsv(sst[i], j)) begin lo++; j--; end
        pub = lo > 0;
      end
      md[i] = pub && mv[i] && !m_ready;
      if (pub && (!mv[i] || m_ready)) begin
        mv[i] = 1;
        ml[i] = lo > mx[i] ? mx[i] : lo;
        mh[i] = hi > mx[i] ? mx[i] : hi;
        ms[i] = (ml[i] == mx[i]) || (mh[i] == mx[i]);
      end else if (!pub && m_ready) mv[i] = 0;
    end
  endtask

  task automatic chk(string tag, int obs, int exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s t=%0t: got %h expected %h", tag, $time, obs, exp);
  endtask

  function automatic int pack(int i);
    return (mv[i] << (2*wid[i]+2)) | (ml[i] << (wid[i]+2)) | (mh[i] << 2) | (ms[i] << 1) | md[i];
  endfunction

  task automatic cyc(bit dv, bit rdy);
    @(negedge clk);
    d = dv;
    m_ready = rdy;
    @(posedge clk);
    model_edge();
    #1;
    chk("sync0_w8", int'({v0, l0, h0, s0, dr0}), pack(0));
    chk("sync2_w4", int'({v1, l1, h1, s1, dr1}), pack(1));
  endtask

  task automatic hold(bit dv, int n, int rm);
    for (int i = 0; i < n; i++)
      cyc(dv, rm == 2 ? ($urandom_range(0, 9) < 7) : rm[0]);
  endtask

  task automatic reset_cyc(bit dv);
    rst = 1'b1;
    cyc(dv, 1'b0);
    rst = 1'b0;
  endtask

  initial begin
    reset_cyc(0);
    hold(0, 5, 1); hold(1, 3, 1); hold(0, 4, 1);
    reset_cyc(1);
    hold(1, 4, 1); hold(0, 2, 1); hold(1, 2, 1); hold(0, 4, 1);
    reset_cyc(0);
    hold(0, 20, 1); hold(1, 1, 1); hold(0, 4, 1);
    reset_cyc(0);
    hold(0, 3, 0); hold(1, 2, 0); hold(0, 4, 0); hold(1, 1, 0); hold(0, 3, 0); hold(0, 3, 1);
    reset_cyc(0);
    for (int i = 0; i < 10; i++) begin hold(1, 1, 1); hold(0, 1, 1); end
    hold(0, 3, 1);
    reset_cyc(0);
    hold(0, 3, 1); hold(1, 3, 1); hold(0, 3, 0); hold(1, 2, 0);
    reset_cyc(1);
    hold(0, 4, 1);
    reset_cyc(0);
    for (int p = 0; p < 40; p++) begin
      hold(0, ($urandom_range(0, 7) == 0) ? 20 : $urandom_range(1, 6), 2);
      hold(1, $urandom_range(1, 5), 2);
      if (p == 25) reset_cyc(1);
    end
    hold(0, 5, 1);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
